// File: rtl/fd48_pkg.sv
// Shared types and constants for the fd48 register-bank controllers.
package fd48_pkg;

    localparam int unsigned FD48_WIDTH = 8;
    localparam int unsigned FD48_CNT_W = 4;
    localparam int unsigned FD48_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        PRESET = 2'd2,
        PDONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick
    import fd48_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]            req,
    input  logic [FD48_IDX_W-1:0]   ptr,
    output logic [N-1:0]            gnt,
    output logic [FD48_IDX_W-1:0]   idx,
    output logic                    valid
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            int unsigned pos;
            logic [SW-1:0] sel;
            pos = 32'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel = SW'(pos);
            if (!valid && req[sel]) begin
                gnt[sel] = 1'b1;
                idx      = FD48_IDX_W'(pos);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fd48_bank_arbiter.sv
// Round-robin write arbiter and preset sequencer for one shared 8-bit preset-able flop bank.
module fd48_bank_arbiter
    import fd48_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned WIDTH         = FD48_WIDTH,
    parameter int unsigned PRESET_CYCLES = 2,
    parameter bit          RESET_PRESET  = 1'b1
) (
    input  logic                   CP,
    input  logic                   RST,
    input  logic [N-1:0]           REQ,
    input  logic [N*WIDTH-1:0]     WDATA,
    output logic [N-1:0]           ACK,
    output logic [FD48_IDX_W-1:0]  GNT_ID,
    input  logic                   PRESET_REQ,
    output logic                   PRESET_ACK,
    output logic                   BUSY,
    input  logic [WIDTH-1:0]       BANK_Q,
    output logic [WIDTH-1:0]       BANK_D,
    output logic                   BANK_SD
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    state_t                  state_q, state_d;
    logic [FD48_IDX_W-1:0]   ptr_q, ptr_d;
    logic [FD48_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic                    rst_pre_q, rst_pre_d;
    logic [N-1:0]            ack_d;
    logic [FD48_IDX_W-1:0]   gnt_d;
    logic                    pack_d;
    logic                    sd_d;

    logic [N-1:0]            pick_gnt;
    logic [FD48_IDX_W-1:0]   pick_idx;
    logic                    pick_valid;
    logic [WIDTH-1:0]        wd [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign wd[i] = WDATA[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N(N)) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Bank recirculates its own Q except during the single write cycle.
    assign BANK_D = (state_q == WRITE) ? wdata_q : BANK_Q;
    assign BUSY   = (state_q != IDLE);

    always_ff @(posedge CP) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rst_pre_q  <= RESET_PRESET;
            ACK        <= '0;
            GNT_ID     <= '0;
            PRESET_ACK <= 1'b0;
            BANK_SD    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rst_pre_q  <= rst_pre_d;
            ACK        <= ack_d;
            GNT_ID     <= gnt_d;
            PRESET_ACK <= pack_d;
            BANK_SD    <= sd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        rst_pre_d = rst_pre_q;
        ack_d     = '0;
        gnt_d     = GNT_ID;
        pack_d    = 1'b0;
        sd_d      = 1'b1;
        case (state_q)
            IDLE: begin
                // A pending post-reset preset or an explicit request beats writes.
                if (rst_pre_q || PRESET_REQ) begin
                    state_d   = PRESET;
                    cnt_d     = '0;
                    sd_d      = 1'b0;
                    rst_pre_d = 1'b0;
                end else if (pick_valid) begin
                    state_d = WRITE;
                    ack_d   = pick_gnt;
                    gnt_d   = pick_idx;
                    wdata_d = wd[SW'(pick_idx)];
                end
            end
            WRITE: begin
                state_d = IDLE;
                ptr_d   = (GNT_ID == FD48_IDX_W'(N - 1)) ? '0 : GNT_ID + 3'd1;
            end
            PRESET: begin
                if (cnt_q == FD48_CNT_W'(PRESET_CYCLES - 1)) begin
                    state_d = PDONE;
                    pack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sd_d  = 1'b0;
                end
            end
            PDONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fd48_bank_arbiter.sv
// Directed bench for fd48_bank_arbiter with a transaction-level reference model and a flop-bank stand-in.
module tb_fd48_bank_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned PC = 2;

    localparam int P_IDLE = 0, P_WRITE = 1, P_PRESET = 2, P_DONE = 3;

    logic           CP;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] WDATA;
    logic [N-1:0]   ACK;
    logic [2:0]     GNT_ID;
    logic           PRESET_REQ;
    logic           PRESET_ACK;
    logic           BUSY;
    logic [W-1:0]   bank_q;
    logic [W-1:0]   BANK_D;
    logic           BANK_SD;

    int errors = 0;
    int checks = 0;

    // reference model state
    int           m_phase = P_IDLE;
    int           m_left  = 0;
    int           m_ptr   = 0;
    int           m_gnt   = 0;
    logic [N-1:0] m_ack   = '0;
    bit           m_pack  = 1'b0;
    bit           m_sd    = 1'b1;
    bit           m_pend  = 1'b0;
    logic [W-1:0] m_bank  = '0;
    logic [W-1:0] m_wdata = '0;
    bit           m_bank_ok = 1'b0;
    bit           m_live    = 1'b0;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Stand-in for the 8-bit D flop bank with async active-low preset.
    always @(posedge CP or negedge BANK_SD) begin
        if (!BANK_SD) bank_q <= '1;
        else          bank_q <= BANK_D;
    end

    fd48_bank_arbiter #(
        .N(N), .WIDTH(W), .PRESET_CYCLES(PC), .RESET_PRESET(1'b1)
    ) dut (
        .CP(CP), .RST(RST), .REQ(REQ), .WDATA(WDATA), .ACK(ACK), .GNT_ID(GNT_ID),
        .PRESET_REQ(PRESET_REQ), .PRESET_ACK(PRESET_ACK), .BUSY(BUSY),
        .BANK_Q(bank_q), .BANK_D(BANK_D), .BANK_SD(BANK_SD)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        if (m_phase == P_WRITE) m_bank = m_wdata;
        if (RST) begin
            m_phase = P_IDLE; m_ptr = 0; m_gnt = 0; m_ack = '0;
            m_pack = 1'b0; m_sd = 1'b1; m_left = 0; m_pend = 1'b1; m_live = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    m_ack = '0; m_pack = 1'b0;
                    g = pick(REQ, m_ptr);
                    if (m_pend || PRESET_REQ) begin
                        m_phase = P_PRESET; m_left = PC; m_sd = 1'b0; m_pend = 1'b0;
                    end else if (g >= 0) begin
                        m_phase = P_WRITE; m_gnt = g; m_ack = '0; m_ack[g] = 1'b1;
                        m_wdata = W'(WDATA >> (g * W));
                    end
                end
                P_WRITE: begin
                    m_phase = P_IDLE; m_ack = '0; m_ptr = (m_gnt + 1) % N;
                end
                P_PRESET: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_DONE; m_sd = 1'b1; m_pack = 1'b1;
                    end
                end
                default: begin
                    m_phase = P_IDLE; m_pack = 1'b0;
                end
            endcase
        end
        if (!m_sd) begin
            m_bank = '1; m_bank_ok = 1'b1;
        end
    endtask

    task automatic compare();
        if (!m_live) return;
        chk("ack", ACK, m_ack);
        chk("gnt_id", GNT_ID, m_gnt);
        chk("preset_ack", PRESET_ACK, m_pack);
        chk("busy", BUSY, m_phase != P_IDLE);
        chk("bank_sd", BANK_SD, m_sd);
        if (m_phase == P_WRITE) chk("bank_d_write", BANK_D, m_wdata);
        if (m_bank_ok) begin
            chk("bank_q", bank_q, m_bank);
            if (m_phase != P_WRITE) chk("bank_d_hold", BANK_D, m_bank);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CP);
            model_edge();
            @(negedge CP);
            compare();
        end
    endtask

    initial begin
        int sd_low, packs, ng, g, bad;
        bit got, early;
        int gseq[5];
        int gcyc[5];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        RST = 1'b1; REQ = '0; PRESET_REQ = 1'b0; WDATA = '0;
        step(2);
        chk("rst_sd", BANK_SD, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_ack", ACK, 0);

        // automatic preset after reset
        RST = 1'b0;
        sd_low = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1);
            if (BANK_SD === 1'b0) sd_low++;
            if (PRESET_ACK === 1'b1) got = 1'b1;
        end
        chk("rp_ack_seen", got, 1);
        chk("rp_sd_low", sd_low, 2);
        chk("rp_bank", bank_q, 8'hFF);
        step(1);
        chk("rp_busy_after", BUSY, 0);

        // fairness with all requests held
        WDATA = {8'h13, 8'h12, 8'h11, 8'h10};
        REQ = 4'b1111;
        ng = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (ACK !== '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (ACK[i]) g = i;
                if (ng < 5) begin gseq[ng] = g; gcyc[ng] = c; end
                ng++;
            end
        end
        REQ = '0;
        chk("fair_count", ng, 5);
        for (int i = 0; i < 5; i++) chk("fair_order", gseq[i], exp_order[i]);
        for (int i = 1; i < 5; i++) chk("fair_gap", gcyc[i] - gcyc[i-1], 2);
        chk("fair_bank", bank_q, 8'h10);
        step(1);

        // single write from requester 2
        WDATA = {8'h00, 8'hA5, 8'h00, 8'h00};
        REQ = 4'b0100;
        step(1);
        chk("w2_ack", ACK, 4'b0100);
        chk("w2_gnt", GNT_ID, 2);
        REQ = '0;
        step(1);
        chk("w2_bank", bank_q, 8'hA5);
        chk("w2_ack_drop", ACK, 0);
        step(1);
        chk("w2_hold", BANK_D, 8'hA5);

        // preset and write requested together: preset wins
        WDATA = {8'h00, 8'h00, 8'h00, 8'h5A};
        REQ = 4'b0001; PRESET_REQ = 1'b1;
        got = 1'b0; early = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1);
            if (ACK !== '0) early = 1'b1;
            if (PRESET_ACK === 1'b1) got = 1'b1;
        end
        PRESET_REQ = 1'b0;
        chk("pw_preset_seen", got, 1);
        chk("pw_no_early_ack", early, 0);
        chk("pw_bank_ff", bank_q, 8'hFF);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            step(1);
            if (ACK !== '0) got = 1'b1;
        end
        chk("pw_ack", ACK, 4'b0001);
        REQ = '0;
        step(1);
        chk("pw_bank", bank_q, 8'h5A);
        step(1);

        // reset during the second preset cycle
        PRESET_REQ = 1'b1;
        step(2);
        chk("rp2_sd_low", BANK_SD, 0);
        RST = 1'b1;
        step(1);
        chk("rp2_sd_rst", BANK_SD, 1);
        RST = 1'b0;
        sd_low = 0; packs = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (BANK_SD === 1'b0) sd_low++;
            if (PRESET_ACK === 1'b1) begin packs++; PRESET_REQ = 1'b0; end
        end
        PRESET_REQ = 1'b0;
        chk("rp2_sd_cycles", sd_low, 2);
        chk("rp2_ack_count", packs, 1);

        // quiet bank holds its value
        WDATA = {8'h00, 8'h00, 8'h3C, 8'h00};
        REQ = 4'b0010;
        step(1);
        REQ = '0;
        step(1);
        chk("idle_bank_start", bank_q, 8'h3C);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (bank_q !== 8'h3C || BANK_SD !== 1'b1 || ACK !== '0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);
        chk("idle_bank_end", bank_q, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
